bram12_arbiter: RTL and testbench
=================================

Name: bram12_arbiter

Overview:
- Two-port access controller in front of one bram12 instance (1W/1R, 1-cycle registered read).
- Shares the RAM between a host requester (Wishbone/AXI-Lite config side: tap/coef load, readback) and an engine requester (FIR datapath), and runs a sequenced clear of all words on request.
- Sits between the bus/engine logic and the bram12 ports; the only block driving bram12.

Parameters:
- ADDR_WIDTH, 12, address width of the RAM and of both requester ports.
- SIZE, 12, number of valid words; addresses >= SIZE are out of range.
- BIT_WIDTH, 32, data word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- clr_start  in  1  pulse: start clearing words 0..SIZE-1 to zero.
- clr_busy  out  1  high while the clear sequence runs.
- h_req / e_req  in  1  host / engine access request; held until granted.
- h_we / e_we  in  1  1 = write, 0 = read; stable while req is high.
- h_addr / e_addr  in  ADDR_WIDTH  word address.
- h_wdata / e_wdata  in  BIT_WIDTH  write data.
- h_gnt / e_gnt  out  1  combinational grant; access executes this cycle.
- h_rvalid / e_rvalid  out  1  read data valid, exactly 1 cycle after a granted read.
- h_rdata / e_rdata  out  BIT_WIDTH  read data; 0 when the matching rvalid is low.
- bram_we, bram_re  out  1  to bram12 we/re.
- bram_waddr, bram_raddr  out  ADDR_WIDTH  to bram12 waddr/raddr.
- bram_wdi  out  BIT_WIDTH  to bram12 wdi.
- bram_rdo  in  BIT_WIDTH  from bram12 rdo.

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high. On rst: state IDLE, clear counter 0, clr_busy 0, both rvalid 0, rdata 0, priority pointer = engine. Reset mid-clear aborts the clear; words already zeroed stay zero.
- FSM IDLE:
  - clr_start=1 -> CLEAR. clr_start wins over any simultaneous request, which gets no grant that cycle.
  - Otherwise at most one grant per cycle. A lone requester is always granted.
  - Both requesting: winner chosen per the priority rule (see Optional Feature).
- FSM CLEAR:
  - No grants; requests wait.
  - Each cycle: bram_we=1, bram_waddr=cnt, bram_wdi=0; cnt increments 0..SIZE-1. SIZE cycles total.
  - On cnt==SIZE-1 -> IDLE; clr_busy drops the following cycle.
  - clr_start during CLEAR is ignored.
- Granted write: bram_we=1, waddr/wdi from the winner, same cycle.
- Granted read: bram_re=1, raddr from the winner, same cycle.
- Read return: a registered tag records the winner and an out-of-range flag. Next cycle the winner's rvalid=1 and rdata=bram_rdo, or 0 if the address was out of range.
- Out-of-range address (>= SIZE): still granted. Write suppressed (bram_we=0). Read returns 0 with rvalid.
- Back-to-back: a requester may hold req across cycles and gets consecutive grants if it keeps winning. Reads pipeline at 1/cycle.
- Idle cycles: bram_we=bram_re=0; address/data outputs 0.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. When both request, the grant goes to the requester not granted most recently; the pointer updates on every grant.
- Undefined: fixed priority, engine over host; host is granted only when e_req=0.

Decomposition:
- Shared package bram12_arb_pkg:
  - FSM state enum {IDLE, CLEAR}
  - requester-id typedef {REQ_HOST, REQ_ENG}
  - default width constants.
- One natural sub-module, bram12_arb_pick: combinational 2-way pick (fixed or RR) plus pointer register.
- FSM, clear counter and read-tag pipeline stay in the top.

Test Plan:
- Reset, then host writes 0xDEADBEEF to addr 3; host reads addr 3 -> h_gnt same cycle, h_rvalid next cycle, h_rdata=0xDEADBEEF, e_rvalid stays 0.
- Both request reads (addr 1 and 2) for 4 cycles:
  - without ARB_RR_EN -> e_gnt all 4 cycles, h_gnt never;
  - with it -> grants alternate E,H,E,H and rdata is routed to the correct requester.
- Preload all 12 words with 0xFFFFFFFF, pulse clr_start -> clr_busy high 12 cycles, bram_we with waddr 0..11 and wdi 0; subsequent reads of 0..11 return 0.
- clr_start in the same cycle as h_req write -> no h_gnt for 12 cycles; write granted the cycle after clear ends and the value reads back.
- Host write to addr 12 and read of addr 15 -> both granted, bram_we=0, read rvalid=1 with rdata=0.
- rst asserted at clear cycle 5 -> clr_busy=0 next cycle; words 0..4 are 0, words 5..11 retain the preloaded value.

Source files
------------

// File: rtl/bram12_arb_pkg.sv
// bram12_arb_pkg: shared types and default widths for the bram12 access
// controller (FSM state, requester id, registered read-return tag).
package bram12_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_SIZE       = 12;
    localparam int unsigned DEF_BIT_WIDTH  = 32;

    typedef enum logic {IDLE, CLEAR} state_t;

    typedef enum logic {REQ_HOST, REQ_ENG} req_id_t;

    // One-deep read-return tag: who issued the read and whether the
    // address was out of range (data forced to zero on return).
    typedef struct packed {
        logic    vld;
        req_id_t id;
        logic    oor;
    } rd_tag_t;

endpackage

// File: rtl/bram12_arb_pick.sv
// bram12_arb_pick: combinational 2-way grant pick plus priority pointer.
//   clk, rst       : clock, synchronous active-high reset
//   en             : grants allowed this cycle (FSM idle, no clear start)
//   h_req, e_req   : host / engine requests
//   h_gnt, e_gnt   : one-hot (or zero) grants
// Macro ARB_RR_EN: defined -> round-robin, the pointer flips to the
// requester not granted last; undefined -> pointer pinned to engine, which
// gives fixed engine-over-host priority.
module bram12_arb_pick
    import bram12_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic h_req,
    input  logic e_req,
    output logic h_gnt,
    output logic e_gnt
);

    // ptr names the requester that wins a tie
    req_id_t ptr;

    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        if (en) begin
            if (h_req && e_req) begin
                if (ptr == REQ_HOST) h_gnt = 1'b1;
                else                 e_gnt = 1'b1;
            end else begin
                h_gnt = h_req;
                e_gnt = e_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        ptr <= REQ_ENG;
`ifdef ARB_RR_EN
        else if (h_gnt) ptr <= REQ_ENG;
        else if (e_gnt) ptr <= REQ_HOST;
`else
        else            ptr <= REQ_ENG;
`endif
    end

endmodule

// File: rtl/bram12_arbiter.sv
// bram12_arbiter: sole driver of one bram12 (1W/1R, 1-cycle registered read).
// Shares the RAM between a host and an engine requester and runs a
// sequenced clear of words 0..SIZE-1.
//   clk, rst                    : clock, synchronous active-high reset
//   clr_start / clr_busy        : clear start pulse / clear in progress
//   h_* / e_*                   : host / engine req, we, addr, wdata, gnt,
//                                 rvalid, rdata (gnt is combinational)
//   bram_we/re/waddr/raddr/wdi  : to bram12; bram_rdo from bram12
// Macro ARB_RR_EN selects round-robin arbitration (default: engine first).
module bram12_arbiter
    import bram12_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned SIZE       = DEF_SIZE,
    parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  clr_busy,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [BIT_WIDTH-1:0]  h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [BIT_WIDTH-1:0]  h_rdata,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [BIT_WIDTH-1:0]  e_wdata,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [BIT_WIDTH-1:0]  e_rdata,
    output logic                  bram_we,
    output logic                  bram_re,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    output logic [BIT_WIDTH-1:0]  bram_wdi,
    input  logic [BIT_WIDTH-1:0]  bram_rdo
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    rd_tag_t               tag;

    logic                  en, gnt, w_we, oor;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BIT_WIDTH-1:0]  w_wdata;

    // No RAM traffic while in reset, so a reset landing mid-clear leaves
    // the current word untouched.
    assign en = !rst && (state == IDLE) && !clr_start;

    bram12_arb_pick u_pick (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .h_req (h_req),
        .e_req (e_req),
        .h_gnt (h_gnt),
        .e_gnt (e_gnt)
    );

    assign gnt     = h_gnt | e_gnt;
    assign w_we    = h_gnt ? h_we    : e_we;
    assign w_addr  = h_gnt ? h_addr  : e_addr;
    assign w_wdata = h_gnt ? h_wdata : e_wdata;
    assign oor     = ({1'b0, w_addr} >= (ADDR_WIDTH+1)'(SIZE));

    always_comb begin
        bram_we    = 1'b0;
        bram_re    = 1'b0;
        bram_waddr = '0;
        bram_raddr = '0;
        bram_wdi   = '0;
        if (!rst && state == CLEAR) begin
            bram_we    = 1'b1;
            bram_waddr = cnt;
        end else if (gnt) begin
            if (w_we) begin
                // out-of-range writes are granted but dropped
                if (!oor) begin
                    bram_we    = 1'b1;
                    bram_waddr = w_addr;
                    bram_wdi   = w_wdata;
                end
            end else begin
                bram_re    = 1'b1;
                bram_raddr = w_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            tag      <= '0;
        end else begin
            tag.vld <= gnt && !w_we;
            tag.id  <= h_gnt ? REQ_HOST : REQ_ENG;
            tag.oor <= oor;
            case (state)
                IDLE: if (clr_start) begin
                    state    <= CLEAR;
                    cnt      <= '0;
                    clr_busy <= 1'b1;
                end
                CLEAR: begin
                    if (cnt == ADDR_WIDTH'(SIZE - 1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign h_rvalid = tag.vld && (tag.id == REQ_HOST);
    assign e_rvalid = tag.vld && (tag.id == REQ_ENG);
    assign h_rdata  = (h_rvalid && !tag.oor) ? bram_rdo : '0;
    assign e_rdata  = (e_rvalid && !tag.oor) ? bram_rdo : '0;

endmodule

// File: tb/tb_bram12_arbiter.sv
// tb_bram12_arbiter: table-driven check of bram12_arbiter against a
// behavioural bram12, plus hand sequences for clear and reset-mid-clear.
module tb_bram12_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_start, clr_busy;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [11:0] h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic        e_req, e_we, e_gnt, e_rvalid;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    logic        bram_we, bram_re;
    logic [11:0] bram_waddr, bram_raddr;
    logic [31:0] bram_wdi, bram_rdo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bram12_arbiter dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .bram_we(bram_we), .bram_re(bram_re), .bram_waddr(bram_waddr),
        .bram_raddr(bram_raddr), .bram_wdi(bram_wdi), .bram_rdo(bram_rdo)
    );

    // behavioural bram12: 1W/1R, registered read
    logic [31:0] mem [0:15];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bram_rdo = 32'h0;
    end
    always @(posedge clk) begin
        if (bram_we) mem[bram_waddr[3:0]] <= bram_wdi;
        if (bram_re) bram_rdo <= mem[bram_raddr[3:0]];
    end

    typedef struct {
        string       nm;
        logic        hr, hw;
        logic [11:0] ha;
        logic [31:0] hd;
        logic        er, ew;
        logic [11:0] ea;
        logic [31:0] ed;
        logic        xhg, xeg, xwe;
        logic [11:0] xwa;
        logic        xre;
        logic [11:0] xra;
        logic        xhv;
        logic [31:0] xhd;
        logic        xev;
        logic [31:0] xed;
    } vec_t;

    function automatic vec_t mkv(input string nm,
        input logic hr, input logic hw, input logic [11:0] ha, input logic [31:0] hd,
        input logic er, input logic ew, input logic [11:0] ea, input logic [31:0] ed,
        input logic xhg, input logic xeg, input logic xwe, input logic [11:0] xwa,
        input logic xre, input logic [11:0] xra,
        input logic xhv, input logic [31:0] xhd, input logic xev, input logic [31:0] xed);
        vec_t v;
        v.nm = nm; v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
        v.xhg = xhg; v.xeg = xeg; v.xwe = xwe; v.xwa = xwa;
        v.xre = xre; v.xra = xra;
        v.xhv = xhv; v.xhd = xhd; v.xev = xev; v.xed = xed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic hr, input logic hw,
                         input logic [11:0] ha, input logic [31:0] hd,
                         input logic er, input logic ew,
                         input logic [11:0] ea, input logic [31:0] ed);
        clr_start = clr;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 12'(i), 32'hFFFF_FFFF, 1'b0, 1'b0, 12'd0, 32'd0);
        end
        @(negedge clk);
        idle();
    endtask

    // host reads words 0..11 back to back; words below nzero expect 0,
    // the rest expect the preload pattern
    task automatic readback(input string nm, input int nzero);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i < 12) drive(1'b0, 1'b1, 1'b0, 12'(i), 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
            else        idle();
            #1;
            if (i > 0) begin
                chk($sformatf("%s.rvalid[%0d]", nm, i-1), 32'(h_rvalid), 32'd1);
                chk($sformatf("%s.rdata[%0d]", nm, i-1), h_rdata,
                    (i - 1 < nzero) ? 32'h0 : 32'hFFFF_FFFF);
            end
        end
    endtask

    // clr_start pulse, optionally with a simultaneous host write to word 7
    task automatic do_clear(input logic with_host);
        string nm;
        nm = with_host ? "clrh" : "clr";
        @(negedge clk);
        drive(1'b1, with_host, 1'b1, 12'd7, 32'h5A5A_5A5A, 1'b0, 1'b0, 12'd0, 32'd0);
        #1;
        chk({nm, ".start_busy"}, 32'(clr_busy), 32'd0);
        chk({nm, ".start_hgnt"}, 32'(h_gnt), 32'd0);
        chk({nm, ".start_we"}, 32'(bram_we), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clr_start = (i == 3);  // restart attempt mid-clear must be ignored
            #1;
            chk($sformatf("%s.busy[%0d]", nm, i), 32'(clr_busy), 32'd1);
            chk($sformatf("%s.we[%0d]", nm, i), 32'(bram_we), 32'd1);
            chk($sformatf("%s.waddr[%0d]", nm, i), 32'(bram_waddr), 32'(i));
            chk($sformatf("%s.wdi[%0d]", nm, i), bram_wdi, 32'd0);
            chk($sformatf("%s.hgnt[%0d]", nm, i), 32'(h_gnt), 32'd0);
        end
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        chk({nm, ".end_busy"}, 32'(clr_busy), 32'd0);
        chk({nm, ".end_hgnt"}, 32'(h_gnt), 32'(with_host));
        if (with_host) begin
            chk({nm, ".end_we"}, 32'(bram_we), 32'd1);
            chk({nm, ".end_waddr"}, 32'(bram_waddr), 32'd7);
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 12'd7, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0);
            @(negedge clk);
            idle();
            #1;
            chk({nm, ".rb_valid"}, 32'(h_rvalid), 32'd1);
            chk({nm, ".rb_data"}, h_rdata, 32'h5A5A_5A5A);
        end
    endtask

    vec_t vecs [16];

    initial begin
        vecs[0]  = mkv("hwr3",  1,1,12'd3,32'hDEADBEEF, 0,0,0,0, 1,0,1,12'd3, 0,0, 0,0, 0,0);
        vecs[1]  = mkv("hrd3",  1,0,12'd3,0,            0,0,0,0, 1,0,0,0, 1,12'd3, 0,0, 0,0);
        vecs[2]  = mkv("hret3", 0,0,0,0,                0,0,0,0, 0,0,0,0, 0,0, 1,32'hDEADBEEF, 0,0);
        vecs[3]  = mkv("ewr5",  0,0,0,0, 1,1,12'd5,32'h12345678, 0,1,1,12'd5, 0,0, 0,0, 0,0);
        vecs[4]  = mkv("erd5",  0,0,0,0, 1,0,12'd5,0,            0,1,0,0, 1,12'd5, 0,0, 0,0);
        vecs[5]  = mkv("eret5", 0,0,0,0, 0,0,0,0,                0,0,0,0, 0,0, 0,0, 1,32'h12345678);
        vecs[6]  = mkv("ewr2",  0,0,0,0, 1,1,12'd2,32'h22222222, 0,1,1,12'd2, 0,0, 0,0, 0,0);
        vecs[7]  = mkv("hwr1",  1,1,12'd1,32'h11111111, 0,0,0,0, 1,0,1,12'd1, 0,0, 0,0, 0,0);
`ifdef ARB_RR_EN
        vecs[8]  = mkv("both0", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 0,0, 0,0);
        vecs[9]  = mkv("both1", 1,0,12'd1,0, 1,0,12'd2,0, 1,0,0,0, 1,12'd1, 0,0, 1,32'h22222222);
        vecs[10] = mkv("both2", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 1,32'h11111111, 0,0);
        vecs[11] = mkv("both3", 1,0,12'd1,0, 1,0,12'd2,0, 1,0,0,0, 1,12'd1, 0,0, 1,32'h22222222);
        vecs[12] = mkv("bothr", 0,0,0,0,     0,0,0,0,     0,0,0,0, 0,0,     1,32'h11111111, 0,0);
`else
        vecs[8]  = mkv("both0", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 0,0, 0,0);
        vecs[9]  = mkv("both1", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 0,0, 1,32'h22222222);
        vecs[10] = mkv("both2", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 0,0, 1,32'h22222222);
        vecs[11] = mkv("both3", 1,0,12'd1,0, 1,0,12'd2,0, 0,1,0,0, 1,12'd2, 0,0, 1,32'h22222222);
        vecs[12] = mkv("bothr", 0,0,0,0,     0,0,0,0,     0,0,0,0, 0,0,     0,0, 1,32'h22222222);
`endif
        vecs[13] = mkv("hwr12", 1,1,12'd12,32'hAAAA5555, 0,0,0,0, 1,0,0,0, 0,0, 0,0, 0,0);
        vecs[14] = mkv("hrd15", 1,0,12'd15,0,            0,0,0,0, 1,0,0,0, 1,12'd15, 0,0, 0,0);
        vecs[15] = mkv("hret15",0,0,0,0,                 0,0,0,0, 0,0,0,0, 0,0, 1,32'h0, 0,0);

        // reset
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.clr_busy", 32'(clr_busy), 32'd0);
        chk("rst.h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rst.e_rvalid", 32'(e_rvalid), 32'd0);
        chk("rst.h_rdata",  h_rdata, 32'd0);
        chk("rst.e_rdata",  e_rdata, 32'd0);
        chk("rst.bram_we",  32'(bram_we), 32'd0);
        chk("rst.bram_re",  32'(bram_re), 32'd0);

        // table vectors, one per cycle
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive(1'b0, vecs[k].hr, vecs[k].hw, vecs[k].ha, vecs[k].hd,
                  vecs[k].er, vecs[k].ew, vecs[k].ea, vecs[k].ed);
            #1;
            chk({vecs[k].nm, ".h_gnt"},    32'(h_gnt),    32'(vecs[k].xhg));
            chk({vecs[k].nm, ".e_gnt"},    32'(e_gnt),    32'(vecs[k].xeg));
            chk({vecs[k].nm, ".bram_we"},  32'(bram_we),  32'(vecs[k].xwe));
            chk({vecs[k].nm, ".waddr"},    32'(bram_waddr), 32'(vecs[k].xwa));
            chk({vecs[k].nm, ".wdi"},      bram_wdi,
                vecs[k].xwe ? (vecs[k].xhg ? vecs[k].hd : vecs[k].ed) : 32'd0);
            chk({vecs[k].nm, ".bram_re"},  32'(bram_re),  32'(vecs[k].xre));
            chk({vecs[k].nm, ".raddr"},    32'(bram_raddr), 32'(vecs[k].xra));
            chk({vecs[k].nm, ".h_rvalid"}, 32'(h_rvalid), 32'(vecs[k].xhv));
            chk({vecs[k].nm, ".h_rdata"},  h_rdata,       vecs[k].xhd);
            chk({vecs[k].nm, ".e_rvalid"}, 32'(e_rvalid), 32'(vecs[k].xev));
            chk({vecs[k].nm, ".e_rdata"},  e_rdata,       vecs[k].xed);
        end

        // full clear after preload
        preload();
        do_clear(1'b0);
        readback("clr_rb", 12);

        // clear racing a host write
        do_clear(1'b1);

        // reset during clear cycle with cnt == 5
        preload();
        @(negedge clk);
        clr_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
            #1;
            chk($sformatf("rstclr.waddr[%0d]", i), 32'(bram_waddr), 32'(i));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstclr.we_in_rst", 32'(bram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstclr.busy", 32'(clr_busy), 32'd0);
        readback("rstclr_rb", 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
